// File: rtl/diff_manch.sv
// Differential Manchester line encoder: one NRZ bit in, two half-bit line levels out.
// Boundary transition depends on d; a mid-bit transition always occurs.
module diff_manch #(
  parameter int unsigned HALF_BIT_CYCLES = 1,
  parameter int unsigned ZERO_TRANSITION = 1,
  parameter int unsigned IDLE_LEVEL      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned BIT_CYCLES = 2 * HALF_BIT_CYCLES;
  localparam int unsigned CNT_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BIT_CYCLES);
  localparam logic             IDLE_Q   = (IDLE_LEVEL != 0);
  localparam logic             ZERO_TR  = (ZERO_TRANSITION != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             bnd_flip;

  // Phase counter and line level update
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    q_d      = q_q;
    bnd_flip = ZERO_TR ? ~d : d;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
    if (cnt_q == '0) begin
      q_d = q_q ^ bnd_flip;
    end else if (cnt_q == CNT_MID) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      q_q   <= IDLE_Q;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_diff_manch.sv
// Bench for diff_manch: four parameterisations driven with directed and random
// bit streams, checked against a per-bit half-level waveform model.
module tb_diff_manch;

  localparam int unsigned NI   = 4;
  localparam int unsigned MAXB = 64;

  logic          clk;
  logic          rst;
  logic [NI-1:0] dv;
  logic [NI-1:0] qv;

  int total;
  int bad;

  logic bits_m   [NI][MAXB];
  logic first_m  [NI][MAXB];
  logic second_m [NI][MAXB];

  diff_manch #(.HALF_BIT_CYCLES(1), .ZERO_TRANSITION(1), .IDLE_LEVEL(0)) u_dut0 (
    .clk(clk), .rst(rst), .d(dv[0]), .q(qv[0]));
  diff_manch #(.HALF_BIT_CYCLES(3), .ZERO_TRANSITION(1), .IDLE_LEVEL(0)) u_dut1 (
    .clk(clk), .rst(rst), .d(dv[1]), .q(qv[1]));
  diff_manch #(.HALF_BIT_CYCLES(1), .ZERO_TRANSITION(0), .IDLE_LEVEL(0)) u_dut2 (
    .clk(clk), .rst(rst), .d(dv[2]), .q(qv[2]));
  diff_manch #(.HALF_BIT_CYCLES(2), .ZERO_TRANSITION(0), .IDLE_LEVEL(1)) u_dut3 (
    .clk(clk), .rst(rst), .d(dv[3]), .q(qv[3]));

  function automatic int half_of(input int k);
    case (k)
      1:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic zt_of(input int k);
    return (k == 0 || k == 1);
  endfunction

  function automatic logic idle_of(input int k);
    return (k == 3);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Model: each bit n is a pair of half-bit levels; a 'flip' at the boundary
  // happens for d=0 (zero-transition) or d=1 (one-transition).
  task automatic build_model(input int mode);
    for (int k = 0; k < NI; k++) begin
      logic prev;
      prev = idle_of(k);
      for (int n = 0; n < MAXB; n++) begin
        logic b;
        case (mode)
          0:       b = 1'b0;
          1:       b = 1'b1;
          2:       b = (n % 2 == 0);
          default: b = 1'($urandom_range(0, 1));
        endcase
        bits_m[k][n]   = b;
        first_m[k][n]  = (b == 1'b0) == zt_of(k) ? ~prev : prev;
        second_m[k][n] = ~first_m[k][n];
        prev           = second_m[k][n];
      end
    end
  endtask

  function automatic logic expected_q(input int k, input int e);
    int hb;
    hb = e / half_of(k);
    return (hb % 2 == 0) ? first_m[k][hb / 2] : second_m[k][hb / 2];
  endfunction

  task automatic reset_hold(input int sess);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dv = NI'($urandom);
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++)
        check_bit($sformatf("rst_hold s%0d i%0d c%0d", sess, k, c), qv[k], idle_of(k));
    end
  endtask

  task automatic run_session(input int sess, input int mode, input int len);
    build_model(mode);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 0; e < len; e++) begin
      for (int k = 0; k < NI; k++)
        dv[k] = bits_m[k][e / (2 * half_of(k))];
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++)
        check_bit($sformatf("enc s%0d i%0d e%0d", sess, k, e), qv[k], expected_q(k, e));
      @(negedge clk);
    end
    // asynchronous reset mid-bit, observed before the next rising edge
    #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      check_bit($sformatf("rst_async s%0d i%0d", sess, k), qv[k], idle_of(k));
    reset_hold(sess);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    dv    = '0;
    reset_hold(-1);
    run_session(0, 0, 24);
    run_session(1, 1, 24);
    run_session(2, 2, 24);
    for (int s = 3; s < 15; s++)
      run_session(s, 3, int'($urandom_range(5, 60)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
